muldiv_ctrl: RTL and testbench



---
 rtl/muldiv_ctrl.sv | 158 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative RV32M multiply/divide sequencer for the EX stage (shift-add / shift-subtract).
// Optional macro MULDIV_FAST_MUL_EN: multiplies complete in one cycle; divides stay iterative.
module muldiv_ctrl #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic              negp_q, negp_d;
    logic              negr_q, negr_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic            a_sgn, b_sgn, a_neg, b_neg, div0, ovf, fast_mul;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [2*XLEN-1:0] fast_prod;

    // Operand decode: only mulhsu mixes signedness; mulhu/divu/remu are fully unsigned.
    assign a_sgn = ~(Funct3[0] & (Funct3[1] | Funct3[2]));
    assign b_sgn = a_sgn & (Funct3 != 3'b010);
    assign a_neg = a_sgn & A[XLEN-1];
    assign b_neg = b_sgn & B[XLEN-1];
    assign a_mag = a_neg ? -A : A;
    assign b_mag = b_neg ? -B : B;
    assign div0  = Funct3[2] & (B == '0);
    assign ovf   = Funct3[2] & ~Funct3[0] & (A == {1'b1, {(XLEN-1){1'b0}}}) & (B == '1);

`ifdef MULDIV_FAST_MUL_EN
    assign fast_mul  = ~Funct3[2];
    assign fast_prod = {{XLEN{a_neg}}, A} * {{XLEN{b_neg}}, B};
`else
    assign fast_mul  = 1'b0;
    assign fast_prod = '0;
`endif

    logic [XLEN:0]     mul_sum, rem_sh, rem_diff;
    logic              rem_ge;
    logic [2*XLEN-1:0] mul_nxt, div_nxt, step, prod_fin;
    logic [XLEN-1:0]   quo_fin, rem_fin, fin_res;

    // acc holds {partial product, multiplier} for multiplies and {remainder, quotient} for divides.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
    assign mul_nxt  = {mul_sum, acc_q[XLEN-1:1]};
    assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    assign rem_diff = rem_sh - {1'b0, dvs_q};
    assign rem_ge   = ~rem_diff[XLEN];
    assign div_nxt  = {(rem_ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], rem_ge};
    assign step     = op_q[2] ? div_nxt : mul_nxt;

    assign prod_fin = negp_q ? -step : step;
    assign quo_fin  = negp_q ? -step[XLEN-1:0] : step[XLEN-1:0];
    assign rem_fin  = negr_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];

    always_comb begin
        case (op_q)
            3'b000:                 fin_res = prod_fin[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fin_res = prod_fin[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fin_res = quo_fin;
            default:                fin_res = rem_fin;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        dvs_d    = dvs_q;
        negp_d   = negp_q;
        negr_d   = negr_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    op_d    = Funct3;
                    cnt_d   = '0;
                    negp_d  = a_neg ^ b_neg;
                    negr_d  = a_neg;
                    state_d = S_BUSY;
                    if (Funct3[2]) begin
                        acc_d = {{XLEN{1'b0}}, a_mag};
                        dvs_d = b_mag;
                    end else begin
                        acc_d = {{XLEN{1'b0}}, b_mag};
                        dvs_d = a_mag;
                    end
                    if (div0) begin
                        result_d = Funct3[1] ? A : '1;
                        state_d  = S_DONE;
                    end else if (ovf) begin
                        result_d = Funct3[1] ? '0 : A;
                        state_d  = S_DONE;
                    end else if (fast_mul) begin
                        result_d = (Funct3 == 3'b000) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
                        state_d  = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN-1)) begin
                        result_d = fin_res;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            dvs_q    <= '0;
            negp_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            dvs_q    <= dvs_d;
            negp_q   <= negp_d;
            negr_q   <= negr_d;
            result_q <= result_d;
        end
    end

    assign stall  = rstn & (((state_q == S_IDLE) & start & ~flush) | (state_q == S_BUSY));
    assign done   = (state_q == S_DONE);
    assign result = result_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: vector table, hand-written corner sequences, random ops vs model.
module tb_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        rstn, start, flush;
    logic [2:0]  Funct3;
    logic [31:0] A, B;
    logic        stall, done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    muldiv_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rstn(rstn), .start(start), .Funct3(Funct3), .A(A), .B(B),
        .flush(flush), .stall(stall), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb, q;
        longint      sp;
        longint unsigned up;
        logic        ov;
        sa = a;
        sb = b;
        ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin sp = longint'(sa) * longint'(sb); return sp[31:0]; end
            3'd1: begin sp = longint'(sa) * longint'(sb); return sp[63:32]; end
            3'd2: begin sp = longint'(sa) * longint'(b);  return sp[63:32]; end
            3'd3: begin up = longint'(a) * longint'(b);   return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ov) return a;
                q = sa / sb; return q;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ov) return 32'h0;
                q = sa % sb; return q;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && b == 0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        if (!f3[2]) return MUL_LAT;
        return 33;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Start one op in the current cycle (cycle 0) and observe stall/done/result cycle by cycle.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int          lat, done_at, n_done;
        logic        stall_ok;
        logic [31:0] res;
        lat = exp_lat(f3, a, b);
        done_at = -1; n_done = 0; stall_ok = 1'b1; res = '0;
        start = 1'b1; Funct3 = f3; A = a; B = b;
        for (int k = 0; k <= lat + 2; k++) begin
            #4;
            if (stall !== (k < lat)) stall_ok = 1'b0;
            if (done === 1'b1) begin
                n_done++;
                if (done_at < 0) begin done_at = k; res = result; end
            end
            tick();
            start = 1'b0; Funct3 = 3'($urandom); A = $urandom; B = $urandom;
        end
        check({name, " latency"}, done_at, lat);
        check({name, " pulses"}, n_done, 1);
        check({name, " stall"}, 32'(stall_ok), 32'd1);
        check({name, " result"}, res, exp);
    endtask

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a, b, exp;
    } vec_t;

    function automatic logic [31:0] pick();
        logic [31:0] sp [5];
        sp[0] = 32'h0; sp[1] = 32'h1; sp[2] = 32'hFFFF_FFFF; sp[3] = 32'h8000_0000; sp[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        vec_t        vecs [16];
        int          n_done, done_at, done2_at;
        logic [31:0] r, r2, prev;
        logic [2:0]  f3;

        vecs[0]  = '{"mul",          3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{"mulh",         3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{"mulhu",        3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3]  = '{"mulhsu",       3'd2, 32'hFFFF_FFFF,  32'h0000_0002, 32'hFFFF_FFFF};
        vecs[4]  = '{"div",          3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        vecs[5]  = '{"rem",          3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        vecs[6]  = '{"divu",         3'd5, 32'd100,        32'd7,         32'd14};
        vecs[7]  = '{"remu",         3'd7, 32'd100,        32'd7,         32'd2};
        vecs[8]  = '{"div0",         3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF};
        vecs[9]  = '{"rem0",         3'd6, 32'd5,          32'd0,         32'd5};
        vecs[10] = '{"div_ovf",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[11] = '{"rem_ovf",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0};
        vecs[12] = '{"remu0",        3'd7, 32'd9,          32'd0,         32'd9};
        vecs[13] = '{"div_negneg",   3'd4, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd3};
        vecs[14] = '{"rem_posneg",   3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1};
        vecs[15] = '{"divu_big",     3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};

        rstn = 1'b0; start = 1'b0; flush = 1'b0; Funct3 = '0; A = '0; B = '0;
        tick(); tick();
        #4;
        check("reset stall", 32'(stall), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        tick();
        rstn = 1'b1;

        foreach (vecs[i]) run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp);

        // start with flush in IDLE must not be accepted
        start = 1'b1; flush = 1'b1; Funct3 = 3'd5; A = 32'd50; B = 32'd3;
        #4; check("idle flush stall", 32'(stall), 32'd0);
        tick(); start = 1'b0; flush = 1'b0;
        #4; check("idle flush not busy", 32'(stall), 32'd0);
        tick();

        // flush in BUSY cycle 10, then a new start at cycle 12
        prev = 32'd0;   // result of the last table vector (divu_big)
        n_done = 0;
        start = 1'b1; Funct3 = 3'd5; A = 32'd1000; B = 32'd3;
        for (int k = 0; k < 11; k++) begin
            flush = (k == 10);
            #4; if (done === 1'b1) n_done++;
            tick(); start = 1'b0;
        end
        flush = 1'b0;
        #4;
        check("flush stall", 32'(stall), 32'd0);
        check("flush done", 32'(done) + 32'(n_done), 32'd0);
        check("flush result kept", result, prev);
        tick();
        run_op("post-flush divu", 3'd5, 32'd1000, 32'd3, 32'd333);

        // synchronous reset in BUSY cycle 5
        start = 1'b1; Funct3 = 3'd0; A = 32'd3; B = 32'd5;
        for (int k = 0; k < 5; k++) begin tick(); start = 1'b0; end
        rstn = 1'b0;
        #4; check("rst busy stall", 32'(stall), 32'd0);
        tick(); rstn = 1'b1;
        #4;
        check("rst result", result, 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst stall", 32'(stall), 32'd0);
        n_done = 0;
        for (int k = 0; k < 36; k++) begin tick(); #4; if (done === 1'b1) n_done++; end
        check("rst no done", n_done, 0);
        tick();

        // flush in DONE is ignored
        start = 1'b1; Funct3 = 3'd4; A = 32'd5; B = 32'd0;
        tick(); start = 1'b0; flush = 1'b1;
        #4;
        check("done flush pulse", 32'(done), 32'd1);
        check("done flush result", result, 32'hFFFF_FFFF);
        tick(); flush = 1'b0;
        #4; check("done flush single", 32'(done), 32'd0);
        tick();

        // start held through BUSY/DONE; operands changed after acceptance
        n_done = 0; done_at = -1; done2_at = -1; r = '0; r2 = '0;
        start = 1'b1; Funct3 = 3'd5; A = 32'd100; B = 32'd7;
        for (int k = 0; k < 70; k++) begin
            if (k >= 1) begin A = 32'd50; B = 32'd3; end
            start = (k <= 34);
            #4;
            if (k == 34) check("held reaccept stall", 32'(stall), 32'd1);
            if (done === 1'b1) begin
                n_done++;
                if (done_at < 0) begin done_at = k; r = result; end
                else if (done2_at < 0) begin done2_at = k; r2 = result; end
            end
            tick();
        end
        start = 1'b0;
        check("held first done", done_at, 33);
        check("held first result", r, 32'd14);
        check("held second done", done2_at, 67);
        check("held second result", r2, 32'd16);
        check("held pulses", n_done, 2);

        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom);
            A = pick(); B = pick();
            r = A; r2 = B;
            run_op("rand", f3, r, r2, model(f3, r, r2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
